// File: rtl/key_choose_gen.sv
// Two-button up/down request generator: per-key synchronizer and debounce feeding a
// hold/auto-repeat FSM that emits one-cycle choose pulses for a counter.
module key_choose_gen #(
    parameter int unsigned DB_CYCLES  = 1000000,
    parameter int unsigned REP_DELAY  = 50000000,
    parameter int unsigned REP_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up,
    input  logic       key_down,
    output logic [2:0] choose,
    output logic       held_up,
    output logic       held_down,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UP_HOLD   = 2'd1,
        DOWN_HOLD = 2'd2,
        LOCK      = 2'd3
    } state_t;

    localparam logic [2:0]  CH_IDLE  = 3'b000;
    localparam logic [2:0]  CH_UP    = 3'b001;
    localparam logic [2:0]  CH_DOWN  = 3'b100;
    localparam logic [31:0] DB_LAST  = 32'(DB_CYCLES - 1);
    localparam logic [31:0] REP_DLY  = 32'(REP_DELAY);
    localparam logic [31:0] REP_PER  = 32'(REP_PERIOD);

    // Index 0 is the up key, index 1 the down key.
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  db_q, db_d;
    logic [31:0] db_cnt_q [2];
    logic [31:0] db_cnt_d [2];

    state_t      state_q;
    logic [31:0] rep_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {key_down, key_up};
            sync2_q <= sync1_q;
        end
    end

    // The level flips on the cycle the disagreement count would reach DB_CYCLES,
    // so the counter never exceeds DB_CYCLES-1 and cannot wrap.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            db_d[k]     = db_q[k];
            db_cnt_d[k] = 32'd0;
            if (sync2_q[k] != db_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    db_d[k]     = ~db_q[k];
                    db_cnt_d[k] = 32'd0;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_q        <= 2'b00;
            db_cnt_q[0] <= 32'd0;
            db_cnt_q[1] <= 32'd0;
        end else begin
            db_q        <= db_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    // Release beats a due repeat, and a second key beats a due repeat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rep_q   <= 32'd0;
            choose  <= CH_IDLE;
        end else begin
            choose <= CH_IDLE;
            case (state_q)
                IDLE: begin
                    if (db_q[0] && !db_q[1]) begin
                        state_q <= UP_HOLD;
                        choose  <= CH_UP;
                        rep_q   <= REP_DLY;
                    end else if (db_q[1] && !db_q[0]) begin
                        state_q <= DOWN_HOLD;
                        choose  <= CH_DOWN;
                        rep_q   <= REP_DLY;
                    end else if (db_q[0] && db_q[1]) begin
                        state_q <= LOCK;
                    end
                end
                UP_HOLD: begin
                    if (!db_q[0]) begin
                        state_q <= IDLE;
                        rep_q   <= 32'd0;
                    end else if (db_q[1]) begin
                        state_q <= LOCK;
                        rep_q   <= 32'd0;
                    end else if (rep_q == 32'd1) begin
                        choose <= CH_UP;
                        rep_q  <= REP_PER;
                    end else if (rep_q != 32'd0) begin
                        rep_q <= rep_q - 32'd1;
                    end
                end
                DOWN_HOLD: begin
                    if (!db_q[1]) begin
                        state_q <= IDLE;
                        rep_q   <= 32'd0;
                    end else if (db_q[0]) begin
                        state_q <= LOCK;
                        rep_q   <= 32'd0;
                    end else if (rep_q == 32'd1) begin
                        choose <= CH_DOWN;
                        rep_q  <= REP_PER;
                    end else if (rep_q != 32'd0) begin
                        rep_q <= rep_q - 32'd1;
                    end
                end
                LOCK: begin
                    if (!db_q[0] && !db_q[1]) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rep_q   <= 32'd0;
                end
            endcase
        end
    end

    assign held_up     = db_q[0];
    assign held_down   = db_q[1];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_choose_gen.sv
// Bench for key_choose_gen: table of clean presses plus hand sequences for reset, bounce,
// conflict and reset-mid-hold; every choose pulse is matched against an expected queue.
module tb_key_choose_gen;

    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int W   = 35;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_up;
    logic       key_down;
    logic [2:0] choose;
    logic       held_up;
    logic       held_down;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic prev_nz = 1'b0;
    logic [W-1:0] exp_q[$];

    key_choose_gen #(
        .DB_CYCLES (DB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_up     (key_up),
        .key_down   (key_down),
        .choose     (choose),
        .held_up    (held_up),
        .held_down  (held_down),
        .dbg_state_o(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic up;
        int   hold;
        logic exp_held;
        int   npulses;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic exp_push(input logic [2:0] v, input int at);
        logic [31:0] at_w;
        at_w = at;
        exp_q.push_back({v, at_w});
    endtask

    // Scoreboard: every nonzero choose must match the head of the expected queue
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [31:0]  cyc_w;
        cyc_w = cyc;
        if (choose != 3'b000) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL choose_unexpected actual=%b at cycle %0d expected no pulse", choose, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e[34:32] !== choose || e[31:0] !== cyc_w || prev_nz) begin
                    failures++;
                    $display("FAIL choose_pulse actual=%b@%0d (prev_nonzero=%0b) expected=%b@%0d",
                             choose, cyc, prev_nz, e[34:32], e[31:0]);
                end
            end
        end
        prev_nz = ((choose != 3'b000) === 1'b1);
    end

    initial begin
        int c;
        vecs[0] = '{1'b1, 15, 1'b1, 1};
        vecs[1] = '{1'b0, 15, 1'b1, 1};
        vecs[2] = '{1'b1, 33, 1'b1, 4};
        vecs[3] = '{1'b1, 25, 1'b1, 2};
        vecs[4] = '{1'b0, 25, 1'b1, 2};
        vecs[5] = '{1'b0, 21, 1'b1, 2};
        vecs[6] = '{1'b1, 20, 1'b1, 1};
        vecs[7] = '{1'b1, 3,  1'b0, 0};
        vecs[8] = '{1'b1, 4,  1'b1, 1};

        // Reset with both keys held
        rst_n = 1'b0; key_up = 1'b1; key_down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_choose", 32'(choose), 32'd0);
            check("rst_held", 32'({held_up, held_down}), 32'd0);
        end
        c = cyc;
        rst_n = 1'b1; key_down = 1'b0;
        exp_push(3'b001, c + 7);
        repeat (10) step();
        key_up = 1'b0;
        repeat (25) step();
        check("drain_reset", 32'(exp_q.size()), 32'd0);

        // Table of clean single-key presses
        foreach (vecs[i]) begin
            c = cyc;
            for (int n = 0; n < vecs[i].npulses; n++) begin
                int e;
                e = (n == 0) ? 6 : 6 + RD + (n - 1) * RP;
                exp_push(vecs[i].up ? 3'b001 : 3'b100, c + 1 + e);
            end
            for (int k = 0; k < vecs[i].hold + 30; k++) begin
                if (k == 0) begin
                    if (vecs[i].up) key_up = 1'b1; else key_down = 1'b1;
                end
                if (k == vecs[i].hold) begin
                    key_up = 1'b0; key_down = 1'b0;
                end
                step();
                if (k == 4) check("held_edge4", 32'(vecs[i].up ? held_up : held_down), 32'd0);
                if (k == 5) check("held_edge5", 32'(vecs[i].up ? held_up : held_down), 32'(vecs[i].exp_held));
            end
            check("drain_vec", 32'(exp_q.size()), 32'd0);
        end

        // Bounce on key_down, then a clean hold
        for (int k = 0; k < 12; k++) begin
            key_down = ((k % 4) < 2);
            step();
        end
        check("bounce_held", 32'(held_down), 32'd0);
        key_down = 1'b1;
        c = cyc;
        exp_push(3'b100, c + 7);
        repeat (10) step();
        key_down = 1'b0;
        repeat (25) step();
        check("drain_bounce", 32'(exp_q.size()), 32'd0);

        // Conflict: down joins a held up, LOCK until both released
        key_up = 1'b1;
        c = cyc;
        exp_push(3'b001, c + 7);
        repeat (16) step();
        key_down = 1'b1;
        repeat (30) step();
        check("conflict_held", 32'({held_up, held_down}), 32'd3);
        check("conflict_lock", 32'(dbg_state), 32'd3);
        key_up = 1'b0;
        repeat (20) step();
        check("lock_down_only", 32'(dbg_state), 32'd3);
        key_down = 1'b0;
        repeat (15) step();
        check("lock_exit", 32'(dbg_state), 32'd0);
        key_down = 1'b1;
        c = cyc;
        exp_push(3'b100, c + 7);
        repeat (10) step();
        key_down = 1'b0;
        repeat (25) step();
        check("drain_conflict", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of an up hold
        key_up = 1'b1;
        c = cyc;
        exp_push(3'b001, c + 7);
        repeat (16) step();
        rst_n = 1'b0;
        step();
        check("midrst_choose", 32'(choose), 32'd0);
        check("midrst_held", 32'(held_up), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        c = cyc;
        exp_push(3'b001, c + 7);
        exp_push(3'b001, c + 1 + 6 + RD);
        repeat (23) step();
        key_up = 1'b0;
        repeat (30) step();
        check("drain_midrst", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
